time_set_arbiter: RTL and testbench



---
 rtl/time_set_arbiter.sv | 130 +++++++++++++
 tb/tb_time_set_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_arbiter.sv
// ============================================================================
// time_set_arbiter
// Arbitrates edge-detected button/UART time-set requests into the counter's
// load interface. The granted value is held until a 1 Hz tick or a timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module time_set_arbiter #(
    parameter int TIMEOUT = 150000000,
    parameter int CNT_W   = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       load_butoane,
    input  logic [5:0] h_butoane,
    input  logic [5:0] min_butoane,
    input  logic       load_uart,
    input  logic [5:0] h_uart,
    input  logic [5:0] min_uart,
    output logic       load_out,
    output logic [5:0] h_out,
    output logic [5:0] min_out,
    output logic       grant_uart,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic             prev_b, prev_u;
    logic             pend_b, pend_u;
    logic             rise_b, rise_u;
    logic             clr_b, clr_u;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
    logic [5:0]       h_nx, min_nx;
    logic [5:0]       sel_h, sel_min;
    logic             grant_nx, done_nx, err_nx;

    assign rise_b   = load_butoane & ~prev_b;
    assign rise_u   = load_uart & ~prev_u;
    assign load_out = (state == HOLD);
    assign busy     = (state == HOLD);

    // Buttons win whenever both sources are pending.
    assign sel_h   = pend_b ? h_butoane   : h_uart;
    assign sel_min = pend_b ? min_butoane : min_uart;

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        h_nx        = h_out;
        min_nx      = min_out;
        grant_nx    = grant_uart;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        clr_b       = 1'b0;
        clr_u       = 1'b0;
        case (state)
            IDLE: begin
                if (pend_b || pend_u) begin
                    clr_b    = pend_b;
                    clr_u    = ~pend_b;
                    grant_nx = ~pend_b;
                    if (sel_h >= 6'd24 || sel_min >= 6'd60) begin
                        err_nx = 1'b1;
                    end else begin
                        h_nx        = sel_h;
                        min_nx      = sel_min;
                        hold_cnt_nx = '0;
                        state_nx    = HOLD;
                    end
                end
            end
            HOLD: begin
                // Tick has priority over a timeout landing on the same edge.
                if (tick_1hz) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    hold_cnt_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_b     <= 1'b1;
            prev_u     <= 1'b1;
            pend_b     <= 1'b0;
            pend_u     <= 1'b0;
            hold_cnt   <= '0;
            h_out      <= '0;
            min_out    <= '0;
            grant_uart <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_b     <= load_butoane;
            prev_u     <= load_uart;
            // A fresh rise on the grant edge must not be lost.
            pend_b     <= (pend_b & ~clr_b) | rise_b;
            pend_u     <= (pend_u & ~clr_u) | rise_u;
            hold_cnt   <= hold_cnt_nx;
            h_out      <= h_nx;
            min_out    <= min_nx;
            grant_uart <= grant_nx;
            done       <= done_nx;
            err        <= err_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_time_set_arbiter.sv
// ============================================================================
// tb_time_set_arbiter
// Directed self-checking bench for time_set_arbiter (TIMEOUT = 16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_time_set_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       load_butoane;
    logic [5:0] h_butoane;
    logic [5:0] min_butoane;
    logic       load_uart;
    logic [5:0] h_uart;
    logic [5:0] min_uart;
    logic       load_out;
    logic [5:0] h_out;
    logic [5:0] min_out;
    logic       grant_uart;
    logic       busy;
    logic       done;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    time_set_arbiter #(
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .load_butoane (load_butoane),
        .h_butoane    (h_butoane),
        .min_butoane  (min_butoane),
        .load_uart    (load_uart),
        .h_uart       (h_uart),
        .min_uart     (min_uart),
        .load_out     (load_out),
        .h_out        (h_out),
        .min_out      (min_out),
        .grant_uart   (grant_uart),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_ok(input string tag);
        chk({tag, "_load"}, 32'(load_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0;
        load_butoane = 1'b0; h_butoane = '0; min_butoane = '0;
        load_uart = 1'b0; h_uart = '0; min_uart = '0;
        step(); step(); step();

        // Reset state
        chk("rst_load", 32'(load_out), 0);
        chk("rst_h", 32'(h_out), 0);
        chk("rst_min", 32'(min_out), 0);
        chk("rst_grant", 32'(grant_uart), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        step();

        // Button 12:34, tick 10 cycles after load_out rises
        h_butoane = 6'd12; min_butoane = 6'd34; load_butoane = 1'b1;
        step();
        chk("t1_latency1", 32'(load_out), 0);
        step();
        chk("t1_load_rise", 32'(load_out), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_h", 32'(h_out), 12);
        chk("t1_min", 32'(min_out), 34);
        chk("t1_grant", 32'(grant_uart), 0);
        load_butoane = 1'b0;
        h_butoane = 6'd1; min_butoane = 6'd1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("t1_load_hold", 32'(load_out), 1);
            chk("t1_h_stable", 32'(h_out), 12);
        end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("t1_load_fall", 32'(load_out), 0);
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        step();
        chk("t1_done_pulse", 32'(done), 0);

        // Simultaneous rises: buttons 08:15 first, then UART 21:59
        h_butoane = 6'd8; min_butoane = 6'd15;
        h_uart = 6'd21; min_uart = 6'd59;
        load_butoane = 1'b1; load_uart = 1'b1;
        step();
        step();
        chk("t2_load_b", 32'(load_out), 1);
        chk("t2_h_b", 32'(h_out), 8);
        chk("t2_min_b", 32'(min_out), 15);
        chk("t2_grant_b", 32'(grant_uart), 0);
        for (int i = 1; i <= 10; i++) step();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("t2_done_b", 32'(done), 1);
        chk("t2_gap", 32'(load_out), 0);
        step();
        chk("t2_load_u", 32'(load_out), 1);
        chk("t2_h_u", 32'(h_out), 21);
        chk("t2_min_u", 32'(min_out), 59);
        chk("t2_grant_u", 32'(grant_uart), 1);
        for (int i = 1; i <= 10; i++) step();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("t2_done_u", 32'(done), 1);
        chk_idle_ok("t2_end");

        // UART range rejects: h = 24, then min = 60
        load_uart = 1'b0; load_butoane = 1'b0;
        step();
        h_uart = 6'd24; min_uart = 6'd10; load_uart = 1'b1;
        step();
        step();
        chk("t3_err_h", 32'(err), 1);
        chk("t3_done_h", 32'(done), 0);
        chk("t3_h_keep", 32'(h_out), 21);
        chk("t3_min_keep", 32'(min_out), 59);
        chk_idle_ok("t3_h");
        step();
        chk("t3_err_pulse", 32'(err), 0);
        chk_idle_ok("t3_after");
        load_uart = 1'b0;
        step();
        h_uart = 6'd5; min_uart = 6'd60; load_uart = 1'b1;
        step();
        step();
        chk("t3_err_min", 32'(err), 1);
        chk("t3_h_keep2", 32'(h_out), 21);
        chk_idle_ok("t3_min");
        step();

        // Timeout: no tick, load_out high for exactly 16 cycles
        h_butoane = 6'd3; min_butoane = 6'd7; load_butoane = 1'b1;
        step();
        step();
        chk("t4_load_rise", 32'(load_out), 1);
        chk("t4_h", 32'(h_out), 3);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t4_load_hold", 32'(load_out), 1);
            chk("t4_err_early", 32'(err), 0);
        end
        step();
        chk("t4_load_fall", 32'(load_out), 0);
        chk("t4_err", 32'(err), 1);
        chk("t4_done", 32'(done), 0);
        step();
        chk("t4_err_pulse", 32'(err), 0);

        // Level held high across reset release produces no load
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_idle_ok("t5_noload");
        end
        load_butoane = 1'b0;
        step();
        h_butoane = 6'd1; min_butoane = 6'd2; load_butoane = 1'b1;
        step();
        step();
        chk("t5_load", 32'(load_out), 1);
        chk("t5_h", 32'(h_out), 1);
        chk("t5_min", 32'(min_out), 2);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("t5_done", 32'(done), 1);

        // Reset 3 cycles into HOLD with a UART request pending
        load_butoane = 1'b0; load_uart = 1'b0;
        step();
        h_butoane = 6'd4; min_butoane = 6'd5; load_butoane = 1'b1;
        h_uart = 6'd9; min_uart = 6'd9;
        step();
        step();
        chk("t6_load", 32'(load_out), 1);
        load_uart = 1'b1;
        step(); step(); step();
        chk("t6_load_hold", 32'(load_out), 1);
        rst = 1'b1;
        step();
        chk("t6_rst_load", 32'(load_out), 0);
        chk("t6_rst_h", 32'(h_out), 0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_idle_ok("t6_no_uart");
            chk("t6_grant", 32'(grant_uart), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
